lane_packer: RTL and testbench

//   Serial-to-parallel operand loader feeding the 16-input signed summing datapath.

---
 rtl/lane_packer_if.sv | 30 +++
 rtl/lane_packer.sv | 99 +++++++++
 tb/tb_lane_packer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/lane_packer_if.sv
// Stream bundle for lane_packer: sample input stream plus packed-frame output stream.
// A transfer occurs on any rising edge where valid and ready are both high.
// valid never depends on ready, and payload is held stable while valid is high and ready is low.
interface lane_packer_if #(
    parameter int DATAWIDTH = 8,
    parameter int LANES     = 16,
    parameter int SUMWIDTH  = 32
);
    localparam int CW = $clog2(LANES + 1);

    logic [DATAWIDTH-1:0]       in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       flush;
    logic [LANES*DATAWIDTH-1:0] out_lanes;
    logic [SUMWIDTH-1:0]        out_sum;
    logic [CW-1:0]              out_count;
    logic                       out_valid;
    logic                       out_ready;

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_lanes, out_sum, out_count, out_valid
    );

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_lanes, out_sum, out_count, out_valid
    );
endinterface

// File: rtl/lane_packer.sv
// Packs signed serial samples into a LANES-wide frame with a running signed sum,
// then holds the frame until downstream takes it; flush closes a partial frame early.
module lane_packer #(
    parameter int DATAWIDTH = 8,
    parameter int LANES     = 16,
    parameter int SUMWIDTH  = 32
) (
    input  logic           clk,
    input  logic           rst,
    lane_packer_if.slave   bus,
    output logic           o_dbg_state
);
    localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW   = $clog2(LANES + 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                             r_state;
    state_t                             w_next_state;
    logic [IDXW-1:0]                    r_idx;
    logic [LANES-1:0][DATAWIDTH-1:0]    r_lanes;
    logic [SUMWIDTH-1:0]                r_sum;
    logic [CW-1:0]                      r_count;

    logic                               w_fill;
    logic                               w_accept;
    logic                               w_last;
    logic                               w_close;
    logic                               w_release;
    logic [SUMWIDTH-1:0]                w_sample_ext;

    assign w_fill       = (r_state == S_FILL);
    assign w_accept     = bus.in_valid & w_fill;
    assign w_last       = w_accept && (r_idx == IDXW'(LANES - 1));
    // A flush only closes the frame if it would contain at least one sample.
    assign w_close      = w_fill && (w_last || (bus.flush && ((r_idx != '0) || w_accept)));
    assign w_release    = (r_state == S_HOLD) && bus.out_ready;
    assign w_sample_ext = {{(SUMWIDTH-DATAWIDTH){bus.in_data[DATAWIDTH-1]}}, bus.in_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FILL:  if (w_close) w_next_state = S_HOLD;
            S_HOLD:  if (bus.out_ready) w_next_state = S_FILL;
            default: w_next_state = S_FILL;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_FILL:  bus.in_ready  = 1'b1;
            S_HOLD:  bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= '0;
            r_lanes <= '0;
            r_sum   <= '0;
            r_count <= '0;
        end else if (w_release) begin
            r_idx   <= '0;
            r_lanes <= '0;
            r_sum   <= '0;
            r_count <= '0;
        end else if (w_fill) begin
            if (w_accept) begin
                r_lanes[r_idx] <= bus.in_data;
                r_sum          <= r_sum + w_sample_ext;
                r_idx          <= r_idx + IDXW'(1);
            end
            // Count includes a sample accepted in the closing cycle.
            if (w_close) begin
                r_idx   <= '0;
                r_count <= CW'(r_idx) + CW'(w_accept);
            end
        end
    end

    assign bus.out_lanes = r_lanes;
    assign bus.out_sum   = r_sum;
    assign bus.out_count = r_count;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_lane_packer.sv
// Bench for lane_packer: table of frames with hand-derived results, corner sequences,
// and random traffic against a queue-based frame model.
module tb_lane_packer;
    localparam int DW    = 8;
    localparam int LANES = 16;
    localparam int SW    = 32;
    localparam int CW    = $clog2(LANES + 1);
    localparam int W     = CW + SW + LANES * DW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dbg_state;

    always #5 clk = ~clk;

    lane_packer_if #(.DATAWIDTH(DW), .LANES(LANES), .SUMWIDTH(SW)) bus ();

    lane_packer #(.DATAWIDTH(DW), .LANES(LANES), .SUMWIDTH(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: frames closed by the model, oldest first.
    logic [W-1:0]          exp_q[$];
    logic signed [DW-1:0]  m_cur[$];
    bit                    m_hold = 1'b0;

    typedef struct {
        int n;
        int vals[LANES];
        bit flush_last;
        bit flush_idle;
        int exp_count;
        int exp_sum;
    } vec_t;

    vec_t tv[6];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] frame_word(input bit presented);
        logic [LANES*DW-1:0] lanes;
        int                  s;
        lanes = '0;
        s     = 0;
        foreach (m_cur[i]) begin
            lanes[i*DW +: DW] = m_cur[i];
            s += m_cur[i];
        end
        return {(presented ? CW'(m_cur.size()) : CW'(0)), SW'(s), lanes};
    endfunction

    function automatic logic [W-1:0] dut_word();
        return {bus.out_count, bus.out_sum, bus.out_lanes};
    endfunction

    task automatic check_outputs();
        check("in_ready", W'(bus.in_ready), W'(!m_hold));
        check("out_valid", W'(bus.out_valid), W'(m_hold));
        if (m_hold && exp_q.size() > 0)
            check("held_frame", dut_word(), exp_q[0]);
        else
            check("fill_view", dut_word(), frame_word(1'b0));
    endtask

    task automatic model_update(input bit v, input logic [DW-1:0] d, input bit f, input bit r);
        if (!m_hold) begin
            if (v) m_cur.push_back(d);
            if (m_cur.size() == LANES || (f && m_cur.size() > 0)) begin
                exp_q.push_back(frame_word(1'b1));
                m_cur.delete();
                m_hold = 1'b1;
            end
        end else if (r) begin
            m_hold = 1'b0;
            void'(exp_q.pop_front());
        end
    endtask

    // One clock: drive inputs, check present outputs, advance model, step past the edge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit f, input bit r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = f;
        bus.out_ready = r;
        check_outputs();
        model_update(v, d, f, r);
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset_now();
        rst = 1'b0;
        m_cur.delete();
        exp_q.delete();
        m_hold = 1'b0;
        #1;
        check("rst out_valid", W'(bus.out_valid), W'(0));
        check("rst frame", dut_word(), W'(0));
        check("rst in_ready", W'(bus.in_ready), W'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LANES*DW-1:0] exp_lanes;
        logic [SW-1:0]       es;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        for (int k = 0; k < LANES; k++) begin
            tv[0].vals[k] = k + 1;
            tv[1].vals[k] = -128;
            tv[2].vals[k] = 0;
            tv[3].vals[k] = k - 8;
            tv[4].vals[k] = 0;
            tv[5].vals[k] = 127;
        end
        tv[2].vals[0] = 5; tv[2].vals[1] = -3; tv[2].vals[2] = 7;
        tv[4].vals[0] = -7;
        tv[0].n = 16; tv[0].flush_last = 0; tv[0].flush_idle = 0; tv[0].exp_count = 16; tv[0].exp_sum = 136;
        tv[1].n = 16; tv[1].flush_last = 0; tv[1].flush_idle = 0; tv[1].exp_count = 16; tv[1].exp_sum = -2048;
        tv[2].n = 3;  tv[2].flush_last = 0; tv[2].flush_idle = 1; tv[2].exp_count = 3;  tv[2].exp_sum = 9;
        tv[3].n = 16; tv[3].flush_last = 1; tv[3].flush_idle = 0; tv[3].exp_count = 16; tv[3].exp_sum = -8;
        tv[4].n = 1;  tv[4].flush_last = 1; tv[4].flush_idle = 0; tv[4].exp_count = 1;  tv[4].exp_sum = -7;
        tv[5].n = 16; tv[5].flush_last = 0; tv[5].flush_idle = 0; tv[5].exp_count = 16; tv[5].exp_sum = 2032;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", W'(bus.out_valid), W'(0));
        check("reset in_ready", W'(bus.in_ready), W'(1));
        check("reset frame", dut_word(), W'(0));
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < tv[i].n; j++)
                step(1'b1, DW'(tv[i].vals[j]), tv[i].flush_last && (j == tv[i].n - 1), 1'b0);
            if (tv[i].flush_idle) step(1'b0, '0, 1'b1, 1'b0);
            exp_lanes = '0;
            for (int k = 0; k < tv[i].n; k++) exp_lanes[k*DW +: DW] = DW'(tv[i].vals[k]);
            es = tv[i].exp_sum;
            check($sformatf("tv%0d out_valid", i), W'(bus.out_valid), W'(1));
            check($sformatf("tv%0d out_count", i), W'(bus.out_count), W'(tv[i].exp_count));
            check($sformatf("tv%0d out_sum", i), W'(bus.out_sum), W'(es));
            check($sformatf("tv%0d out_lanes", i), W'(bus.out_lanes), W'(exp_lanes));
            step(1'b0, '0, 1'b0, 1'b1);
            step(1'b0, '0, 1'b0, 1'b0);
        end

        // Backpressure: frame held for 5 cycles while upstream pushes and flushes
        for (int j = 0; j < LANES; j++) step(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            check("bp in_ready", W'(bus.in_ready), W'(0));
            check("bp stable", dut_word(), exp_q[0]);
            step(1'b1, 8'h55, 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        check("bp released", W'(bus.out_valid), W'(0));
        step(1'b0, '0, 1'b0, 1'b0);

        // Flush with nothing buffered never yields a frame
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("empty flush", W'(bus.out_valid), W'(0));
        step(1'b0, '0, 1'b0, 1'b0);

        // Reset mid-frame, then a clean frame must sum to 136
        for (int j = 0; j < 7; j++) step(1'b1, DW'(j + 50), 1'b0, 1'b0);
        #2;
        assert_reset_now();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int j = 0; j < LANES; j++) step(1'b1, DW'(j + 1), 1'b0, 1'b0);
        check("post-reset sum", W'(bus.out_sum), W'(136));
        check("post-reset count", W'(bus.out_count), W'(16));

        // Reset while a frame is held
        #2;
        assert_reset_now();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);

        // 1..16 with random valid gaps gives the same frame
        for (int j = 0; j < LANES; j++) begin
            while ($urandom_range(0, 99) < 40) step(1'b0, DW'($urandom_range(0, 255)), 1'b0, 1'b1);
            step(1'b1, DW'(j + 1), 1'b0, 1'b1);
        end
        check("gaps sum", W'(bus.out_sum), W'(136));
        check("gaps count", W'(bus.out_count), W'(16));
        check("gaps valid", W'(bus.out_valid), W'(1));
        step(1'b0, '0, 1'b0, 1'b1);

        // Random traffic against the model
        repeat (1200) begin
            step($urandom_range(0, 99) < 70, DW'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 60);
        end
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
